obi_copy_initiator: RTL and testbench

- Word-copy engine that acts as an initiator (requester) on the processor data-bus protocol (req/gnt/rvalid, we, be, addr, wdata, rdata, err).
- It is the counterpart of the bus responders such as the debug-port controller and boot ROM.
- It reads LEN words from a source address and writes each one to a destination address, one transaction outstanding at a time.
- It sits in processor_block behind a bus arbiter, alongside the core's data port, and is started by a register-level command interface.

---
 rtl/dbus_pkg.sv | 32 +++
 rtl/obi_copy_initiator.sv | 163 ++++++++++++++++
 tb/tb_obi_copy_initiator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// Shared data-bus types for initiators and responders on the processor bus.
// Used by the copy engine, debug-port controller and boot ROM.
package dbus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_WR_WAIT,
      S_FIN
   } copy_state_e;

   localparam logic [3:0]  BE_WORD    = 4'hF;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dbus_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        err;
   } dbus_rsp_t;

endpackage

// File: rtl/obi_copy_initiator.sv
// Word-copy bus initiator: reads len words from src and writes them to dst,
// one transaction outstanding, with an optional response timeout.
module obi_copy_initiator
   import dbus_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             timeout,
   output logic [LEN_W-1:0] words_done,
   output logic             data_req,
   input  logic             data_gnt,
   input  logic             data_rvalid,
   output logic             data_we,
   output logic [3:0]       data_be,
   output logic [31:0]      data_addr,
   output logic [31:0]      data_wdata,
   input  logic [31:0]      data_rdata,
   input  logic             data_err
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST =
      (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   copy_state_e      r_state;
   copy_state_e      w_next;
   logic [31:0]      r_src;
   logic [31:0]      r_dst;
   logic [31:0]      r_buf;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_words;
   logic             r_error;
   logic             r_timeout;
   logic [TW-1:0]    r_tmo;
   dbus_req_t        w_req;
   dbus_rsp_t        w_rsp;
   logic             w_wait;
   logic             w_tmo_hit;
   logic             w_last;

   assign w_rsp = '{gnt:    data_gnt,
                    rvalid: data_rvalid,
                    rdata:  data_rdata,
                    err:    data_err};

   assign w_wait = (r_state == S_RD_WAIT) ||
                   (r_state == S_WR_WAIT);

   // rvalid on the last allowed wait cycle still wins over the timeout
   assign w_tmo_hit = (TIMEOUT > 0) && w_wait &&
                      !w_rsp.rvalid && (r_tmo == TMO_LAST);

   assign w_last = (r_words + LEN_W'(1)) == r_len;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:
            if (start)
               w_next = (len == '0) ? S_FIN : S_RD_REQ;
         S_RD_REQ:
            if (w_rsp.gnt) w_next = S_RD_WAIT;
         S_RD_WAIT:
            if (w_rsp.rvalid)
               w_next = w_rsp.err ? S_FIN : S_WR_REQ;
            else if (w_tmo_hit)
               w_next = S_FIN;
         S_WR_REQ:
            if (w_rsp.gnt) w_next = S_WR_WAIT;
         S_WR_WAIT:
            if (w_rsp.rvalid)
               w_next = (w_rsp.err || w_last) ? S_FIN : S_RD_REQ;
            else if (w_tmo_hit)
               w_next = S_FIN;
         S_FIN:
            w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_req = '0;
      unique case (r_state)
         S_RD_REQ: w_req = '{req: 1'b1, we: 1'b0, be: BE_WORD,
                             addr: r_src, wdata: 32'h0};
         S_WR_REQ: w_req = '{req: 1'b1, we: 1'b1, be: BE_WORD,
                             addr: r_dst, wdata: r_buf};
         default:  w_req = '0;
      endcase
   end

   assign data_req   = w_req.req;
   assign data_we    = w_req.we;
   assign data_be    = w_req.be;
   assign data_addr  = w_req.addr;
   assign data_wdata = w_req.wdata;

   assign busy       = (r_state != S_IDLE) && (r_state != S_FIN);
   assign done       = (r_state == S_FIN);
   assign error      = r_error;
   assign timeout    = r_timeout;
   assign words_done = r_words;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_src     <= '0;
         r_dst     <= '0;
         r_buf     <= '0;
         r_len     <= '0;
         r_words   <= '0;
         r_error   <= 1'b0;
         r_timeout <= 1'b0;
         r_tmo     <= '0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_src     <= {src_addr[31:2], 2'b00};
            r_dst     <= {dst_addr[31:2], 2'b00};
            r_len     <= len;
            r_words   <= '0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
         end
         if ((r_state == S_RD_REQ || r_state == S_WR_REQ) && w_rsp.gnt)
            r_tmo <= '0;
         else if (w_wait)
            r_tmo <= r_tmo + TW'(1);
         if (r_state == S_RD_WAIT && w_rsp.rvalid) begin
            if (w_rsp.err) r_error <= 1'b1;
            else           r_buf   <= w_rsp.rdata;
         end
         if (r_state == S_WR_WAIT && w_rsp.rvalid) begin
            if (w_rsp.err) begin
               r_error <= 1'b1;
            end else begin
               r_words <= r_words + LEN_W'(1);
               r_src   <= r_src + WORD_BYTES;
               r_dst   <= r_dst + WORD_BYTES;
            end
         end
         if (w_tmo_hit) begin
            r_error   <= 1'b1;
            r_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_obi_copy_initiator.sv
// Randomized bench for the copy initiator: a bus responder with a memory
// and a transaction-level model of the expected copy outcome.
module tb_obi_copy_initiator;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] len;
   logic        busy;
   logic        done;
   logic        error;
   logic        timeout;
   logic [15:0] words_done;
   logic        data_req;
   logic        data_gnt;
   logic        data_rvalid;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_err;

   obi_copy_initiator #(.LEN_W(16), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .error(error), .timeout(timeout),
      .words_done(words_done),
      .data_req(data_req), .data_gnt(data_gnt),
      .data_rvalid(data_rvalid), .data_we(data_we),
      .data_be(data_be), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_err(data_err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // responder memory, knobs and transaction log
   logic [31:0] mem [logic [31:0]];
   int gnt_max = 0;
   int rsp_max = 0;
   int err_rd_at = -1;
   int err_wr_at = -1;
   int hang_rd_at = -1;
   int hang_cyc = 0;
   int rd_n = 0;
   int wr_n = 0;
   int stab_bad = 0;
   int proto_bad = 0;
   bit inject_stray = 0;
   logic [31:0] tx_addr[$];
   logic [31:0] tx_wd[$];
   bit          tx_we[$];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   initial begin
      int wcnt, pcnt;
      bit pend, p_we, p_err;
      logic [31:0] p_addr, p_wd, c_addr, c_wd;
      bit c_we;
      pend = 0; wcnt = -1; pcnt = 0;
      p_we = 0; p_err = 0; p_addr = 0; p_wd = 0;
      c_addr = 0; c_wd = 0; c_we = 0;
      data_gnt = 0; data_rvalid = 0; data_err = 0; data_rdata = 0;
      forever begin
         @(negedge clk);
         data_gnt = 0; data_rvalid = 0; data_err = 0; data_rdata = 0;
         if (rst) begin
            pend = 0; wcnt = -1;
         end else if (inject_stray) begin
            data_rvalid = 1; data_rdata = 32'hDEADBEEF;
            inject_stray = 0;
         end else if (pend) begin
            if (data_req) proto_bad++;
            if (pcnt == 0) begin
               data_rvalid = 1; data_err = p_err;
               if (!p_we) data_rdata = mem_rd(p_addr);
               else if (!p_err) mem[p_addr] = p_wd;
               pend = 0;
            end else pcnt--;
         end else if (data_req) begin
            if (wcnt < 0) begin
               wcnt = $urandom_range(gnt_max, 0);
               c_addr = data_addr; c_wd = data_wdata; c_we = data_we;
            end
            if (data_addr !== c_addr || data_wdata !== c_wd ||
                data_we !== c_we || data_be !== 4'hF)
               stab_bad++;
            if (wcnt == 0) begin
               data_gnt = 1;
               tx_addr.push_back(data_addr);
               tx_wd.push_back(data_wdata);
               tx_we.push_back(data_we);
               p_we = data_we; p_addr = data_addr; p_wd = data_wdata;
               p_err = 0; pend = 1; wcnt = -1;
               pcnt = $urandom_range(rsp_max, 0);
               if (!data_we) begin
                  if (rd_n == err_rd_at) p_err = 1;
                  if (rd_n == hang_rd_at) begin
                     pend = 0; hang_cyc = cyc + 1;
                  end
                  rd_n++;
               end else begin
                  if (wr_n == err_wr_at) p_err = 1;
                  wr_n++;
               end
            end else wcnt--;
         end
      end
   end

   task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                           input int n, input int gmax, input int rmax,
                           input int rd_k, input int wr_k,
                           input bit hang, input bit ideal);
      logic [31:0] ex_addr[$];
      logic [31:0] ex_wd[$];
      bit          ex_we[$];
      logic [31:0] sv[$];
      int ex_words, st, dc, k;
      bit ex_err, ex_tmo;
      gnt_max = gmax; rsp_max = rmax;
      err_rd_at  = (rd_k >= 0) ? rd_n + rd_k : -1;
      err_wr_at  = (wr_k >= 0) ? wr_n + wr_k : -1;
      hang_rd_at = hang ? rd_n : -1;
      stab_bad = 0; proto_bad = 0;
      tx_addr.delete(); tx_wd.delete(); tx_we.delete();
      ex_words = 0; ex_err = 0; ex_tmo = 0;
      for (int i = 0; i < n; i++) sv.push_back(mem_rd(src + 32'(4 * i)));
      for (int i = 0; i < n; i++) begin
         ex_addr.push_back(src + 32'(4 * i));
         ex_wd.push_back(32'h0); ex_we.push_back(0);
         if (hang) begin ex_err = 1; ex_tmo = 1; break; end
         if (i == rd_k) begin ex_err = 1; break; end
         ex_addr.push_back(dst + 32'(4 * i));
         ex_wd.push_back(sv[i]); ex_we.push_back(1);
         if (i == wr_k) begin ex_err = 1; break; end
         ex_words++;
      end
      @(negedge clk);
      src_addr = src | 32'($urandom_range(3, 0));
      dst_addr = dst | 32'($urandom_range(3, 0));
      len = 16'(n); start = 1; st = cyc + 1;
      @(negedge clk);
      start = 0; src_addr = $urandom; dst_addr = $urandom;
      chk("busy_after_start", busy, n != 0);
      chk("err_cleared", error, 0);
      k = 0;
      while (!done && k < 3000) begin @(negedge clk); k++; end
      if (!done) begin chk("done_seen", 0, 1); return; end
      dc = cyc;
      if (ideal && !hang) chk("latency", dc - st, 2 * ex_addr.size());
      if (hang) chk("tmo_latency", dc - hang_cyc, 8);
      chk("busy_at_done", busy, 0);
      chk("error", error, ex_err);
      chk("timeout", timeout, ex_tmo);
      chk("words_done", words_done, ex_words);
      chk("tx_count", tx_addr.size(), ex_addr.size());
      for (int i = 0; i < ex_addr.size() && i < tx_addr.size(); i++) begin
         chk($sformatf("tx%0d_addr_we", i), {31'b0, tx_we[i], tx_addr[i]},
             {31'b0, ex_we[i], ex_addr[i]});
         if (ex_we[i]) chk($sformatf("tx%0d_wdata", i), tx_wd[i], ex_wd[i]);
      end
      for (int i = 0; i < ex_words; i++)
         chk($sformatf("mem%0d", i), mem_rd(dst + 32'(4 * i)), sv[i]);
      chk("stable_until_gnt", stab_bad, 0);
      chk("req_drop_after_gnt", proto_bad, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("words_hold", words_done, ex_words);
   endtask

   initial begin
      logic [31:0] s, d;
      int k;
      rst = 1; start = 0; src_addr = 0; dst_addr = 0; len = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_words", words_done, 0);
      chk("rst_req", data_req, 0);

      mem[32'h1000] = 32'hA0; mem[32'h1004] = 32'hA1;
      mem[32'h1008] = 32'hA2;
      run_copy(32'h1000, 32'h2000, 3, 0, 0, -1, -1, 0, 1);
      run_copy(32'h1000, 32'h3000, 3, 5, 2, -1, -1, 0, 0);

      for (int it = 0; it < 4; it++) begin
         s = 32'h10000 | ($urandom & 32'hFFF0);
         d = 32'h80000 | ($urandom & 32'hFFF0);
         run_copy(s, d, $urandom_range(6, 1), 5, 2, -1, -1, 0, 0);
      end

      run_copy(32'h4000, 32'h5000, 0, 0, 0, -1, -1, 0, 1);
      run_copy(32'h6000, 32'h7000, 4, 0, 0, 1, -1, 0, 1);
      run_copy(32'h6000, 32'h7100, 2, 0, 0, -1, -1, 0, 1);
      run_copy(32'h6100, 32'h7200, 4, 3, 1, -1, 2, 0, 0);

      run_copy(32'h9000, 32'hA000, 3, 0, 0, -1, -1, 1, 0);
      inject_stray = 1;
      repeat (3) @(negedge clk);
      chk("stray_busy", busy, 0);
      chk("stray_error_kept", error, 1);
      chk("stray_words", words_done, 0);
      chk("stray_req", data_req, 0);
      run_copy(32'h9100, 32'hA100, 2, 0, 0, -1, -1, 0, 1);

      run_copy(32'hFFFFFFFC, 32'h0000B000, 2, 0, 0, -1, -1, 0, 1);

      gnt_max = 3; rsp_max = 1;
      @(negedge clk);
      src_addr = 32'hC000; dst_addr = 32'hD000; len = 16'd5; start = 1;
      @(negedge clk);
      start = 0;
      k = 0;
      while (!data_req && k < 50) begin @(negedge clk); k++; end
      chk("mid_req_seen", data_req, 1);
      rst = 1;
      @(negedge clk);
      chk("mid_rst_req", data_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      @(negedge clk);
      rst = 0;
      chk("mid_rst_words", words_done, 0);
      run_copy(32'hC100, 32'hD100, 3, 2, 1, -1, -1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
